// File: rtl/data_memory_ws.sv
// MEM-stage data memory: byte/half/word loads and stores with sign/zero extension,
// a configurable number of wait states reported on stall, and rejection of illegal requests.
module data_memory_ws #(
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        size,
   input  logic              unsigned_ld,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       write_data,
   output logic [31:0]       read_data,
   output logic              rvalid,
   output logic              stall,
   output logic              err
);

   localparam int                IDX_W    = $clog2(DEPTH);
   localparam logic [ADDR_W-3:0] DEPTH_WA = (ADDR_W-2)'(DEPTH);
   localparam bit                HAS_WAIT = (WAIT_CYCLES > 0);
   localparam bit                SHORT    = (WAIT_CYCLES <= 1);
   localparam logic [3:0]        CNT_INIT = (WAIT_CYCLES >= 2) ? 4'(WAIT_CYCLES - 2) : 4'd0;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic              r_cap_write;
   logic              r_cap_uns;
   logic [1:0]        r_cap_size;
   logic [1:0]        r_cap_lane;
   logic [IDX_W-1:0]  r_cap_idx;
   logic [31:0]       r_cap_wdata;
   logic [31:0]       r_read_data;
   logic              r_rvalid;
   logic              r_err;
   logic [31:0]       r_mem [DEPTH];

   logic              w_req;
   logic              w_bad;
   logic              w_accept;
   logic              w_from_cap;
   logic              w_do_access;
   logic              w_mem_we;
   logic              w_acc_write;
   logic              w_acc_uns;
   logic [1:0]        w_acc_size;
   logic [1:0]        w_acc_lane;
   logic [IDX_W-1:0]  w_acc_idx;
   logic [31:0]       w_acc_wdata;
   logic [3:0]        w_be;
   logic [31:0]       w_wlanes;
   logic [31:0]       w_rword;
   logic [31:0]       w_rshift;
   logic [31:0]       w_load;

   assign w_req    = mem_read | mem_write;
   assign w_bad    = (mem_read & mem_write)
                   | (size == SZ_RSVD)
                   | ((size == SZ_HALF) & address[0])
                   | ((size == SZ_WORD) & (address[1:0] != 2'b00))
                   | (address[ADDR_W-1:2] >= DEPTH_WA);
   assign w_accept = (r_state == S_IDLE) & w_req & ~w_bad;

   // A single access port: live inputs when the access lands on the accept edge,
   // the captured request when it lands at the end of the wait sequence.
   assign w_from_cap  = (r_state == S_WAIT);
   assign w_do_access = (w_accept & SHORT) | ((r_state == S_WAIT) & (r_cnt == 4'd0));
   assign w_acc_write = w_from_cap ? r_cap_write : mem_write;
   assign w_acc_uns   = w_from_cap ? r_cap_uns   : unsigned_ld;
   assign w_acc_size  = w_from_cap ? r_cap_size  : size;
   assign w_acc_lane  = w_from_cap ? r_cap_lane  : address[1:0];
   assign w_acc_idx   = w_from_cap ? r_cap_idx   : address[IDX_W+1:2];
   assign w_acc_wdata = w_from_cap ? r_cap_wdata : write_data;
   assign w_mem_we    = rst_n & w_do_access & w_acc_write;

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      w_be     = 4'b0000;
      w_wlanes = 32'h0;
      case (w_acc_size)
         SZ_BYTE: begin
            w_be     = 4'b0001 << w_acc_lane;
            w_wlanes = {4{w_acc_wdata[7:0]}};
         end
         SZ_HALF: begin
            w_be     = 4'b0011 << w_acc_lane;
            w_wlanes = {2{w_acc_wdata[15:0]}};
         end
         default: begin
            w_be     = 4'b1111;
            w_wlanes = w_acc_wdata;
         end
      endcase
   end

   assign w_rword  = r_mem[w_acc_idx];
   assign w_rshift = w_rword >> {w_acc_lane, 3'b000};

   always_comb begin
      w_load = w_rshift;
      case (w_acc_size)
         SZ_BYTE: w_load = w_acc_uns ? {24'h0, w_rshift[7:0]}
                                     : {{24{w_rshift[7]}}, w_rshift[7:0]};
         SZ_HALF: w_load = w_acc_uns ? {16'h0, w_rshift[15:0]}
                                     : {{16{w_rshift[15]}}, w_rshift[15:0]};
         default: w_load = w_rshift;
      endcase
   end

   // NOTE: the storage array has no reset; clearing it would turn the RAM into a flop bank.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_acc_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_cap_write <= 1'b0;
         r_cap_uns   <= 1'b0;
         r_cap_size  <= SZ_BYTE;
         r_cap_lane  <= 2'b00;
         r_cap_idx   <= '0;
         r_cap_wdata <= 32'h0;
         r_read_data <= 32'h0;
         r_rvalid    <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         if (w_do_access & ~w_acc_write) begin
            r_read_data <= w_load;
            r_rvalid    <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  if (w_bad) begin
                     r_err <= 1'b1;
                  end else if (HAS_WAIT) begin
                     r_cap_write <= mem_write;
                     r_cap_uns   <= unsigned_ld;
                     r_cap_size  <= size;
                     r_cap_lane  <= address[1:0];
                     r_cap_idx   <= address[IDX_W+1:2];
                     r_cap_wdata <= write_data;
                     r_cnt       <= CNT_INIT;
                     r_state     <= SHORT ? S_DONE : S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) r_state <= S_DONE;
               else               r_cnt   <= r_cnt - 4'd1;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign stall     = rst_n & ((w_accept & HAS_WAIT) | (r_state == S_WAIT));
   assign read_data = r_read_data;
   assign rvalid    = r_rvalid;
   assign err       = r_err;

endmodule

// File: tb/tb_data_memory_ws.sv
// Scoreboarded bench for data_memory_ws: three instances (0, 3 and 2 wait states)
// driven one at a time; a monitor pops expected load/err responses as the DUTs present them.
module tb_data_memory_ws;

   localparam int ADDR_W = 32;
   localparam int DEPTH  = 1024;

   typedef struct {
      int          dut;
      bit          is_err;
      logic [31:0] data;
      string       name;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n       [3];
   logic              mem_read    [3];
   logic              mem_write   [3];
   logic [1:0]        size        [3];
   logic              unsigned_ld [3];
   logic [ADDR_W-1:0] address     [3];
   logic [31:0]       write_data  [3];
   logic [31:0]       read_data   [3];
   logic              rvalid      [3];
   logic              stall       [3];
   logic              err         [3];

   exp_t        q[$];
   logic [31:0] last_rd [3];
   int          n_tests  = 0;
   int          n_fail   = 0;
   int          n_stall0 = 0;

   always #5 clk = ~clk;

   data_memory_ws #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_n0 (
      .clk(clk), .rst_n(rst_n[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
      .size(size[0]), .unsigned_ld(unsigned_ld[0]), .address(address[0]),
      .write_data(write_data[0]), .read_data(read_data[0]), .rvalid(rvalid[0]),
      .stall(stall[0]), .err(err[0]));

   data_memory_ws #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_n3 (
      .clk(clk), .rst_n(rst_n[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
      .size(size[1]), .unsigned_ld(unsigned_ld[1]), .address(address[1]),
      .write_data(write_data[1]), .read_data(read_data[1]), .rvalid(rvalid[1]),
      .stall(stall[1]), .err(err[1]));

   data_memory_ws #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_n2 (
      .clk(clk), .rst_n(rst_n[2]), .mem_read(mem_read[2]), .mem_write(mem_write[2]),
      .size(size[2]), .unsigned_ld(unsigned_ld[2]), .address(address[2]),
      .write_data(write_data[2]), .read_data(read_data[2]), .rvalid(rvalid[2]),
      .stall(stall[2]), .err(err[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every rvalid/err pulse must match the oldest expected response.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (rst_n[d] && (rvalid[d] || err[d])) begin
            if (q.size() == 0) begin
               check($sformatf("unexpected_out_dut%0d", d), {30'h0, err[d], rvalid[d]}, 32'h0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check({e.name, "_dut"}, d, e.dut);
               check({e.name, "_kind"}, {30'h0, err[d], rvalid[d]}, e.is_err ? 32'h2 : 32'h1);
               check({e.name, "_data"}, read_data[d], e.data);
            end
         end
      end
      if (stall[0]) n_stall0++;
   end

   // Present a request and hold it until the cycle with stall low has ended.
   task automatic req(input int d, input bit rd, input bit wr, input logic [1:0] sz,
                      input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                      output int stalls, output bit rv_rel);
      mem_read[d]    = rd;
      mem_write[d]   = wr;
      size[d]        = sz;
      unsigned_ld[d] = uns;
      address[d]     = addr;
      write_data[d]  = wd;
      stalls         = 0;
      @(negedge clk);
      while (stall[d] && stalls < 40) begin
         stalls++;
         @(negedge clk);
      end
      rv_rel = rvalid[d];
      @(posedge clk);
      #1;
      mem_read[d]  = 1'b0;
      mem_write[d] = 1'b0;
   endtask

   task automatic store(input int d, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input int exp_stalls, input string name);
      int s;
      bit rv;
      req(d, 1'b0, 1'b1, sz, 1'b0, addr, wd, s, rv);
      check({name, "_stalls"}, s, exp_stalls);
   endtask

   task automatic load(input int d, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                       input logic [31:0] exp, input int exp_stalls, input string name);
      int s;
      bit rv;
      q.push_back('{d, 1'b0, exp, name});
      last_rd[d] = exp;
      req(d, 1'b1, 1'b0, sz, uns, addr, 32'h0, s, rv);
      check({name, "_stalls"}, s, exp_stalls);
      if (exp_stalls > 0) check({name, "_rvalid_in_done"}, {31'h0, rv}, 32'h1);
   endtask

   task automatic bad(input int d, input bit rd, input bit wr, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] wd, input string name);
      int s;
      bit rv;
      q.push_back('{d, 1'b1, last_rd[d], name});
      req(d, rd, wr, sz, 1'b0, addr, wd, s, rv);
      check({name, "_stalls"}, s, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst_n[d]       = 1'b0;
         mem_read[d]    = 1'b0;
         mem_write[d]   = 1'b0;
         size[d]        = 2'b10;
         unsigned_ld[d] = 1'b0;
         address[d]     = '0;
         write_data[d]  = '0;
         last_rd[d]     = 32'h0;
      end
      // A legal waited request during reset must not raise stall.
      mem_read[1] = 1'b1;
      #12;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset_read_data_dut%0d", d), read_data[d], 32'h0);
         check($sformatf("reset_rvalid_dut%0d", d), {31'h0, rvalid[d]}, 32'h0);
         check($sformatf("reset_err_dut%0d", d), {31'h0, err[d]}, 32'h0);
         check($sformatf("reset_stall_dut%0d", d), {31'h0, stall[d]}, 32'h0);
      end
      @(posedge clk);
      #1;
      mem_read[1] = 1'b0;
      for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

      // Zero wait states: word, byte and half accesses
      store(0, 2'b10, 32'h10, 32'hDEADBEEF, 0, "n0_st_word");
      load (0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, "n0_ld_word");
      store(0, 2'b00, 32'h13, 32'hAAAAAA80, 0, "n0_st_byte");
      load (0, 2'b00, 1'b0, 32'h13, 32'hFFFFFF80, 0, "n0_ld_sbyte");
      load (0, 2'b00, 1'b1, 32'h13, 32'h00000080, 0, "n0_ld_ubyte");
      load (0, 2'b10, 1'b0, 32'h10, 32'h80ADBEEF, 0, "n0_ld_word_merged");
      load (0, 2'b01, 1'b0, 32'h12, 32'hFFFF80AD, 0, "n0_ld_shalf");
      load (0, 2'b01, 1'b1, 32'h12, 32'h000080AD, 0, "n0_ld_uhalf");
      store(0, 2'b01, 32'h22, 32'hFFFF1234, 0, "n0_st_half");
      load (0, 2'b01, 1'b0, 32'h22, 32'h00001234, 0, "n0_ld_half");

      // Rejected requests: err pulse, no stall, read_data unchanged, memory untouched
      bad(0, 1'b1, 1'b0, 2'b01, 32'h21, 32'h0, "n0_err_half_misaligned");
      bad(0, 1'b1, 1'b1, 2'b10, 32'h10, 32'h55555555, "n0_err_rd_wr");
      bad(0, 1'b1, 1'b0, 2'b11, 32'h10, 32'h0, "n0_err_size11");
      bad(0, 1'b1, 1'b0, 2'b10, DEPTH * 4, 32'h0, "n0_err_oor_load");
      bad(0, 1'b0, 1'b1, 2'b10, DEPTH * 4, 32'h66666666, "n0_err_oor_store");
      bad(0, 1'b1, 1'b0, 2'b10, 32'h12, 32'h0, "n0_err_word_misaligned");
      load (0, 2'b10, 1'b0, 32'h10, 32'h80ADBEEF, 0, "n0_ld_after_errors");

      // Three wait states, including a back-to-back store after the load
      store(1, 2'b10, 32'h10, 32'h80ADBEEF, 3, "n3_st_word");
      load (1, 2'b10, 1'b0, 32'h10, 32'h80ADBEEF, 3, "n3_ld_word");
      store(1, 2'b00, 32'h10, 32'h0000007F, 3, "n3_st_byte_b2b");
      load (1, 2'b00, 1'b1, 32'h10, 32'h0000007F, 3, "n3_ld_ubyte");
      load (1, 2'b10, 1'b0, 32'h10, 32'h80ADBE7F, 3, "n3_ld_word_merged");
      bad(1, 1'b1, 1'b0, 2'b11, 32'h10, 32'h0, "n3_err_size11");

      // Two wait states: reset during WAIT drops the store
      store(2, 2'b10, 32'h40, 32'hCAFEF00D, 2, "n2_st_init");
      mem_write[2]  = 1'b1;
      size[2]       = 2'b10;
      address[2]    = 32'h40;
      write_data[2] = 32'h11111111;
      @(negedge clk);
      check("n2_stall_c0", {31'h0, stall[2]}, 32'h1);
      @(negedge clk);
      check("n2_stall_c1_wait", {31'h0, stall[2]}, 32'h1);
      rst_n[2] = 1'b0;
      #1;
      check("n2_stall_drop_on_reset", {31'h0, stall[2]}, 32'h0);
      @(posedge clk);
      #1;
      mem_write[2] = 1'b0;
      rst_n[2]     = 1'b1;
      last_rd[2]   = 32'h0;
      load (2, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 2, "n2_ld_after_reset");

      repeat (3) @(negedge clk);
      check("queue_drained", q.size(), 32'h0);
      check("n0_stall_never", n_stall0, 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
